// File: rtl/serial_addsub_n.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock with a registered ripple carry, start/done handshake.
// Define SERIAL_ADDSUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_addsub_n #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
`ifdef SERIAL_ADDSUB_OVF_EN
   output logic             ovf,
`endif
   output logic [WIDTH:0]   O
);

   localparam int unsigned NSTEP = WIDTH / CHUNK;
   localparam int unsigned CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             r_state;
   logic [WIDTH-1:0]   r_op_a;
   logic [WIDTH-1:0]   r_op_b;
   logic [WIDTH-1:0]   r_res;
   logic               r_carry;
   logic [CNT_W-1:0]   r_count;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH:0]     r_o;

   logic [CHUNK:0]     w_sum;
   logic [WIDTH-1:0]   w_res_next;
   logic               w_last;

   always_comb begin
      w_sum      = {1'b0, r_op_a[CHUNK-1:0]} + {1'b0, r_op_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
      // Result fills from the top so the first chunk ends up at the LSBs.
      w_res_next = r_res >> CHUNK;
      w_res_next[WIDTH-1 -: CHUNK] = w_sum[CHUNK-1:0];
      w_last     = (r_count == CNT_W'(NSTEP - 1));
   end

`ifdef SERIAL_ADDSUB_OVF_EN
   logic w_c_msb_in;
   logic r_ovf;

   // Carry into the operand MSB recovered from the sum bit of the final chunk.
   assign w_c_msb_in = r_op_a[CHUNK-1] ^ r_op_b[CHUNK-1] ^ w_sum[CHUNK-1];
   assign ovf        = r_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (r_state == StRun && w_last) begin
         r_ovf <= w_c_msb_in ^ w_sum[CHUNK];
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_op_a  <= '0;
         r_op_b  <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_count <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_o     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle, StDone: begin
               if (start) begin
                  r_op_a  <= A;
                  r_op_b  <= sub ? ~B : B;
                  r_carry <= sub;
                  r_count <= '0;
                  r_busy  <= 1'b1;
                  r_state <= StRun;
               end else begin
                  r_state <= StIdle;
               end
            end
            StRun: begin
               r_op_a  <= r_op_a >> CHUNK;
               r_op_b  <= r_op_b >> CHUNK;
               r_res   <= w_res_next;
               r_carry <= w_sum[CHUNK];
               r_count <= r_count + CNT_W'(1);
               if (w_last) begin
                  r_o     <= {w_sum[CHUNK], w_res_next};
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= StDone;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign O    = r_o;

endmodule

// File: tb/tb_serial_addsub_n.sv
// Directed self-checking bench for serial_addsub_n: reset, add/sub vectors, handshake, mid-op reset,
// and latency of CHUNK=8 / CHUNK=1 instances.
module tb_serial_addsub_n;

   logic       clk;
   logic       rst;
   logic       start;
   logic       sub;
   logic [7:0] A;
   logic [7:0] B;
   logic       busy,  done;
   logic       busy8, done8;
   logic       busy1, done1;
   logic [8:0] O, O8, O1;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic       ovf, ovf8, ovf1;
`endif

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [8:0] last_o;
   int         lat8, lat1, n_done;

   serial_addsub_n #(.WIDTH(8), .CHUNK(2)) u_dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B),
      .busy(busy), .done(done),
`ifdef SERIAL_ADDSUB_OVF_EN
      .ovf(ovf),
`endif
      .O(O)
   );

   serial_addsub_n #(.WIDTH(8), .CHUNK(8)) u_dut_c8 (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B),
      .busy(busy8), .done(done8),
`ifdef SERIAL_ADDSUB_OVF_EN
      .ovf(ovf8),
`endif
      .O(O8)
   );

   serial_addsub_n #(.WIDTH(8), .CHUNK(1)) u_dut_c1 (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B),
      .busy(busy1), .done(done1),
`ifdef SERIAL_ADDSUB_OVF_EN
      .ovf(ovf1),
`endif
      .O(O1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Full transaction on the CHUNK=2 instance; returns in the done cycle.
   task automatic run_op(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] exp);
      @(negedge clk);
      start = 1'b1; sub = s; A = a; B = b;
      @(negedge clk);
      start = 1'b0; sub = ~s; A = 8'hAA; B = 8'h55;
      check({tag, " run1 busy/done"}, 32'({busy, done}), 32'b10);
      check({tag, " O held in RUN"}, 32'(O), 32'(last_o));
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         check({tag, " run busy/done"}, 32'({busy, done}), 32'b10);
      end
      @(negedge clk);
      check({tag, " done busy/done"}, 32'({busy, done}), 32'b01);
      check({tag, " O"}, 32'(O), 32'(exp));
      last_o = exp;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
      last_o = '0;
      repeat (2) @(negedge clk);
      check("reset busy/done", 32'({busy, done}), 32'b00);
      check("reset O", 32'(O), 32'h000);
      start = 1'b1; A = 8'h03; B = 8'h01;
      @(negedge clk);
      check("start under reset", 32'(busy), 32'd0);
      @(negedge clk);
      check("start under reset 2", 32'(busy), 32'd0);
      start = 1'b0; rst = 1'b0;
      @(negedge clk);

      run_op("add 03+01", 1'b0, 8'h03, 8'h01, 9'h004);
      @(negedge clk);
      check("idle after done", 32'({busy, done}), 32'b00);
      check("O held idle", 32'(O), 32'h004);
      run_op("add FF+FF", 1'b0, 8'hFF, 8'hFF, 9'h1FE);
      run_op("sub 07-05", 1'b1, 8'h07, 8'h05, 9'h102);
      run_op("sub 05-07", 1'b1, 8'h05, 8'h07, 9'h0FE);
      run_op("sub 80-80", 1'b1, 8'h80, 8'h80, 9'h100);
      run_op("add 7F+01", 1'b0, 8'h7F, 8'h01, 9'h080);
`ifdef SERIAL_ADDSUB_OVF_EN
      check("ovf 7F+01", 32'(ovf), 32'd1);
`endif
      run_op("add FF+01", 1'b0, 8'hFF, 8'h01, 9'h100);
`ifdef SERIAL_ADDSUB_OVF_EN
      check("ovf FF+01", 32'(ovf), 32'd0);
`endif
      run_op("sub 80-01", 1'b1, 8'h80, 8'h01, 9'h17F);
`ifdef SERIAL_ADDSUB_OVF_EN
      check("ovf 80-01", 32'(ovf), 32'd1);
`endif
      @(negedge clk);

      // Handshake: restart during RUN is ignored, restart in DONE is accepted.
      start = 1'b1; sub = 1'b0; A = 8'h01; B = 8'h01;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; A = 8'h10; B = 8'h10;
      @(negedge clk);
      start = 1'b0;
      check("hs ignored start busy", 32'({busy, done}), 32'b10);
      @(negedge clk);
      @(negedge clk);
      check("hs done1", 32'({busy, done}), 32'b01);
      check("hs O1", 32'(O), 32'h002);
      start = 1'b1; A = 8'h02; B = 8'h03;
      @(negedge clk);
      start = 1'b0;
      check("hs b2b busy", 32'({busy, done}), 32'b10);
      check("hs O held", 32'(O), 32'h002);
      repeat (3) begin
         @(negedge clk);
         check("hs b2b run", 32'({busy, done}), 32'b10);
      end
      @(negedge clk);
      check("hs done2", 32'({busy, done}), 32'b01);
      check("hs O2", 32'(O), 32'h005);
      @(negedge clk);
      check("hs single done", 32'({busy, done}), 32'b00);

      // Reset during the second RUN cycle.
      start = 1'b1; sub = 1'b0; A = 8'h55; B = 8'h11;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst busy/done", 32'({busy, done}), 32'b00);
      check("midrst O", 32'(O), 32'h000);
      n_done = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("midrst no done", 32'(n_done), 32'd0);
      last_o = '0;

      // Latency of the CHUNK=8 and CHUNK=1 instances, shared operands.
      lat8 = 0; lat1 = 0;
      start = 1'b1; sub = 1'b0; A = 8'h03; B = 8'h01;
      for (int cyc = 1; cyc <= 14; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (done8 && lat8 == 0) lat8 = cyc;
         if (done1 && lat1 == 0) lat1 = cyc;
      end
      check("c8 latency", 32'(lat8), 32'd2);
      check("c1 latency", 32'(lat1), 32'd9);
      check("c8 O", 32'(O8), 32'h004);
      check("c1 O", 32'(O1), 32'h004);
      check("c2 O shared", 32'(O), 32'h004);
      last_o = 9'h004;

      run_op("post-rst sub 00-01", 1'b1, 8'h00, 8'h01, 9'h0FF);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
